// File: rtl/c_sel_sub_21bit_seq.sv
// Multi-cycle 21-bit subtractor D = A - B - bin, one 16/4/1 segment per clock.
// Optional signed-overflow output is enabled with the SUB_OVF_EN macro.
module c_sel_sub_21bit_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [21:1] A,
  input  logic [21:1] B,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [21:1] D,
  output logic        bout
`ifdef SUB_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StSeg0,
    StSeg1,
    StSeg2,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [21:1] a_q, b_q;
  logic        c_q;    // inter-segment carry; a borrow is its complement
  logic [20:1] r_q;

  logic [16:0] sum_lo;
  logic [4:0]  sum_mid;
  logic [1:0]  sum_top;

  // Subtraction as A + ~B + carry, segment by segment.
  always_comb begin
    sum_lo  = {1'b0, a_q[16:1]} + {1'b0, ~b_q[16:1]} + {16'd0, c_q};
    sum_mid = {1'b0, a_q[20:17]} + {1'b0, ~b_q[20:17]} + {4'd0, c_q};
    sum_top = {1'b0, a_q[21]} + {1'b0, ~b_q[21]} + {1'b0, c_q};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StSeg0;
      StSeg0:  state_d = StSeg1;
      StSeg1:  state_d = StSeg2;
      StSeg2:  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= 1'b0;
      r_q  <= '0;
      D    <= '0;
      bout <= 1'b0;
`ifdef SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q <= A;
            b_q <= B;
            c_q <= ~bin;
          end
        end
        StSeg0: begin
          r_q[16:1] <= sum_lo[15:0];
          c_q       <= sum_lo[16];
        end
        StSeg1: begin
          r_q[20:17] <= sum_mid[3:0];
          c_q        <= sum_mid[4];
        end
        StSeg2: begin
          D    <= {sum_top[0], r_q};
          bout <= ~sum_top[1];
`ifdef SUB_OVF_EN
          ovf  <= (a_q[21] ^ b_q[21]) & (sum_top[0] ^ a_q[21]);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
